// File: rtl/ring_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Latency: none; this file only declares types and constants.
// Backpressure: none; no datapath lives here.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  localparam int GATE_MIN_DEFAULT = 8;
  localparam int GATE_SEL_W       = 3;

endpackage

// File: rtl/osc_sync_edge.sv
// Brings the asynchronous oscillator tap into clk and flags its rising edges.
// Latency: 2 cycles from osc_in to osc_edge (two synchroniser flops).
// Backpressure: none; free-running, one-cycle osc_edge pulse per rising edge.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic osc_edge
);

  // sync_sr[0..1] form the synchroniser, sync_sr[2] holds the previous synced value
  logic [2:0] sync_sr;

  // Shift the oscillator sample through the synchroniser and edge-detect flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= 3'b000;
    end else begin
      sync_sr <= {sync_sr[1:0], osc_in};
    end
  end

  assign osc_edge = sync_sr[1] & ~sync_sr[2];

endmodule

// File: rtl/ring_freq_meter.sv
// Gated edge counter: counts osc_in rising edges over 2^(GATE_MIN+gate_sel) clk cycles.
// Latency: done/count/ovf appear W+2 cycles after the start edge is sampled (ARM + W + 1).
// Backpressure: none; start is ignored while busy. Macro RING_FREQ_METER_CONT_EN = continuous mode.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int GATE_MIN = GATE_MIN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  osc_in,
  input  logic                  start,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf
);

  // Timer must hold 2^(GATE_MIN+7)-1, the longest window minus one
  localparam int TMR_W = GATE_MIN + 7;

  meas_state_t      state, state_nxt;
  logic             start_prev;
  logic             start_q;
  logic             osc_edge;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_load;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_final;
  logic             sat;
  logic             cnt_full;
  logic             win_end;
  int               shamt;

  osc_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .osc_edge (osc_edge)
  );

  assign shamt    = GATE_MIN + int'(gate_sel);
  assign tmr_load = (TMR_W'(1) << shamt) - TMR_W'(1);
  assign win_end  = (state == MEASURE) && (tmr == '0);
  assign cnt_full = &edge_cnt;
  // The final cycle's edge is folded in here so the whole window is counted
  assign cnt_final = (osc_edge && !cnt_full) ? edge_cnt + CNT_W'(1) : edge_cnt;

`ifdef RING_FREQ_METER_CONT_EN
  assign start_q = start;
`else
  assign start_q = start & ~start_prev;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and busy flag
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_q) state_nxt = ARM;
      end
      ARM: begin
        busy      = 1'b1;
        state_nxt = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        if (tmr == '0) begin
`ifdef RING_FREQ_METER_CONT_EN
          state_nxt = start ? ARM : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window timer, saturating edge counter and start-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b0;
      tmr        <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
    end else begin
      start_prev <= start;
      if (state == ARM) begin
        tmr      <= tmr_load;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else if (state == MEASURE) begin
        tmr <= tmr - TMR_W'(1);
        if (osc_edge) begin
          if (cnt_full) sat <= 1'b1;
          else          edge_cnt <= edge_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Result registers: updated only when a window completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= win_end;
      if (win_end) begin
        count <= cnt_final;
        // An edge landing on a full counter in the last cycle also overflows
        ovf   <= sat | (osc_edge & cnt_full);
      end
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: directed windows with a done-driven scoreboard.
// Latency: expected done cycle is recorded per window and checked exactly.
// Backpressure: n/a; the monitor flags any done with no expectation queued.
module tb_ring_freq_meter;
  import ring_meas_pkg::*;

  localparam int CNT_W    = 12;
  localparam int GATE_MIN = 8;

  typedef struct {
    longint lo;
    longint hi;
    logic   ovf;
    longint cyc;
  } exp_t;

  logic                  clk      = 1'b0;
  logic                  rst_n    = 1'b0;
  logic                  osc_in   = 1'b0;
  logic                  start    = 1'b0;
  logic [GATE_SEL_W-1:0] gate_sel = '0;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      count;
  logic                  ovf;

  int     n_cmp     = 0;
  int     n_bad     = 0;
  int     osc_div   = 0;
  int     osc_ph    = 0;
  int     done_seen = 0;
  longint cyc       = 0;
  exp_t   sb_q[$];
  exp_t   mon_e;

  ring_freq_meter #(.CNT_W(CNT_W), .GATE_MIN(GATE_MIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .start    (start),
    .gate_sel (gate_sel),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator model: square wave of osc_div clk periods, skewed off the clock edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (osc_div == 0) begin
        osc_in = 1'b0;
        osc_ph = 0;
      end else begin
        osc_ph = (osc_ph + 1) % osc_div;
        osc_in = (osc_ph < osc_div / 2);
      end
    end
  end

  function automatic void check(input string name, input longint act,
                                input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endfunction

  function automatic void push(input longint lo, input longint hi,
                               input logic o, input longint c);
    exp_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = o;
    e.cyc = c;
    sb_q.push_back(e);
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("count", longint'(count), mon_e.lo, mon_e.hi);
        check("ovf", longint'(ovf), longint'(mon_e.ovf), longint'(mon_e.ovf));
        check("done_cycle", cyc, mon_e.cyc, mon_e.cyc);
      end
    end
  end

  task automatic start_pulse(input logic [GATE_SEL_W-1:0] sel, output longint c);
    @(posedge clk);
    #1;
    gate_sel = sel;
    start    = 1'b1;
    c        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({"drain_", name}, longint'(sb_q.size()), 0, 0);
    sb_q.delete();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    longint c;
    int     d0;

    // Reset state
    #12;
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_count", longint'(count), 0, 0);
    check("rst_ovf", longint'(ovf), 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // clk/4, shortest window; gate_sel change mid-window must not alter W
    osc_div = 4;
    repeat (10) @(posedge clk);
    start_pulse(3'd0, c);
    push(64, 64, 1'b0, c + 258);
    repeat (3) @(posedge clk);
    #1;
    gate_sel = 3'd7;
    check("busy_measure", longint'(busy), 1, 1);
    drain(400, "w256");

    // Longest window saturates, then a short one clears ovf
    start_pulse(3'd7, c);
    push(4095, 4095, 1'b1, c + 32770);
    drain(33000, "w32768");
    start_pulse(3'd0, c);
    push(64, 64, 1'b0, c + 258);
    drain(400, "after_sat");

    // Reset 100 cycles into MEASURE: outputs clear, no done afterwards
    start_pulse(3'd1, c);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0, 0);
    check("abort_count", longint'(count), 0, 0);
    check("abort_ovf", longint'(ovf), 0, 0);
    d0 = done_seen;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (600) @(posedge clk);
    check("abort_no_done", longint'(done_seen), longint'(d0), longint'(d0));

    // Silent oscillator; a second start while busy is ignored
    osc_div = 0;
    d0 = done_seen;
    start_pulse(3'd2, c);
    push(0, 0, 1'b0, c + 1026);
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(1200, "w1024");
    repeat (1100) @(posedge clk);
    check("busy_start_ignored", longint'(done_seen), longint'(d0 + 1), longint'(d0 + 1));

    // start held high for 3000 cycles
    osc_div = 4;
    repeat (10) @(posedge clk);
    d0 = done_seen;
    @(posedge clk);
    #1;
    gate_sel = 3'd0;
    start    = 1'b1;
    c        = cyc;
`ifdef RING_FREQ_METER_CONT_EN
    // 11 windows finish inside the hold; the 12th, already armed, completes after release
    for (int k = 0; k < 12; k++) push(64, 64, 1'b0, c + 258 + 257 * k);
`else
    push(64, 64, 1'b0, c + 258);
`endif
    repeat (3000) @(posedge clk);
    #1;
    start = 1'b0;
    drain(600, "held_start");
`ifdef RING_FREQ_METER_CONT_EN
    check("held_done_count", longint'(done_seen), longint'(d0 + 12), longint'(d0 + 12));
`else
    check("held_done_count", longint'(done_seen), longint'(d0 + 1), longint'(d0 + 1));
`endif

    // clk/6 over 512 cycles: 85.3 edges
    osc_div = 6;
    repeat (10) @(posedge clk);
    start_pulse(3'd1, c);
    push(84, 86, 1'b0, c + 514);
    drain(700, "w512");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
